// File: rtl/sync_fifo_param_if.sv
// Push/pop handshake bundle for sync_fifo_param.
// master: producer/consumer side; slave: FIFO side.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              push;
    logic [DATA_W-1:0] wdata;
    logic              pop;
    logic [DATA_W-1:0] rdata;
    logic              flush;
    logic              err_clr;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, wdata, pop, flush, err_clr,
        input  rdata, full, empty, almost_full, almost_empty,
        input  count, overflow, underflow
    );

    modport slave (
        input  push, wdata, pop, flush, err_clr,
        output rdata, full, empty, almost_full, almost_empty,
        output count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with count, almost flags, sticky errors, flush.
// Ports: clk, rst_n (async active-low), bus (sync_fifo_param_if.slave).
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 2**ADDR_W - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   AF_C    = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0]   AE_C    = (ADDR_W+1)'(AE_LEVEL);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              full_q;
    logic              empty_q;
    logic              af_q;
    logic              ae_q;
    logic              ovf_q;
    logic              unf_q;
    logic              wr_en;
    logic              rd_en;
    logic              ovf_evt;
    logic              unf_evt;

    // When full, a simultaneous pop frees the slot the write lands in,
    // so both execute. When empty, the pop has nothing to return.
    always_comb begin
        rd_en   = bus.pop  & ~bus.flush & ~empty_q;
        wr_en   = bus.push & ~bus.flush & (~full_q | bus.pop);
        ovf_evt = bus.push & ~bus.flush & full_q & ~bus.pop;
        unf_evt = bus.pop  & ~bus.flush & empty_q;
        cnt_nxt = cnt;
        if (bus.flush) begin
            cnt_nxt = '0;
        end else if (wr_en & ~rd_en) begin
            cnt_nxt = cnt + CNT_ONE;
        end else if (rd_en & ~wr_en) begin
            cnt_nxt = cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= (AF_C == '0);
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (bus.flush) begin
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (wr_en) wptr <= wptr + PTR_ONE;
                if (rd_en) rptr <= rptr + PTR_ONE;
            end
            cnt     <= cnt_nxt;
            full_q  <= (cnt_nxt == DEPTH_C);
            empty_q <= (cnt_nxt == '0);
            af_q    <= (cnt_nxt >= AF_C);
            ae_q    <= (cnt_nxt <= AE_C);
            // Clear first so a same-edge error event wins.
            if (bus.err_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            if (ovf_evt) ovf_q <= 1'b1;
            if (unf_evt) unf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= bus.wdata;
    end

    assign bus.rdata        = mem[rptr];
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.count        = cnt;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised + directed bench for sync_fifo_param.
// Queue-based reference model, checked every falling edge.
module tb_sync_fifo_param;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    bit   chk_en;

    logic [DW-1:0] m_q [$];
    bit            m_ovf;
    bit            m_unf;

    sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sync_fifo_param #(
        .DATA_W(DW), .ADDR_W(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: expected outputs follow from queue size.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("count", 32'(bus.count), 32'(m_q.size()));
            chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
            chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
            chk("almost_full", 32'(bus.almost_full),
                32'(m_q.size() >= AF));
            chk("almost_empty", 32'(bus.almost_empty),
                32'(m_q.size() <= AE));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("underflow", 32'(bus.underflow), 32'(m_unf));
            if (m_q.size() > 0)
                chk("rdata", 32'(bus.rdata), 32'(m_q[0]));
        end
    end

    task automatic model_edge(input bit p, input logic [DW-1:0] d,
                              input bit po, input bit f, input bit ec);
        bit do_pop;
        bit do_push;
        if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        if (f) begin
            m_q.delete();
        end else begin
            do_pop  = po && (m_q.size() > 0);
            do_push = p && (m_q.size() < DEPTH || do_pop);
            if (p && !do_push) m_ovf = 1'b1;
            if (po && !do_pop) m_unf = 1'b1;
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back(d);
        end
    endtask

    // Called just after a falling edge; returns at the next one.
    task automatic step(input bit p, input logic [DW-1:0] d,
                        input bit po, input bit f, input bit ec);
        bus.push    = p;
        bus.wdata   = d;
        bus.pop     = po;
        bus.flush   = f;
        bus.err_clr = ec;
        @(posedge clk);
        model_edge(p, d, po, f, ec);
        @(negedge clk);
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_ae"}, 32'(bus.almost_empty), 32'd1);
        chk({tag, "_af"}, 32'(bus.almost_full), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
        chk({tag, "_unf"}, 32'(bus.underflow), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp_d;
        n_vec       = 0;
        n_err       = 0;
        chk_en      = 1'b0;
        m_ovf       = 1'b0;
        m_unf       = 1'b0;
        bus.push    = 1'b0;
        bus.wdata   = '0;
        bus.pop     = 1'b0;
        bus.flush   = 1'b0;
        bus.err_clr = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fill with 0x00..0x0F.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
            chk("fill_rdata", 32'(bus.rdata), 32'h00);
            chk("fill_af", 32'(bus.almost_full), 32'(i + 1 >= 14));
        end
        chk("fill_count", 32'(bus.count), 32'd16);
        chk("fill_full", 32'(bus.full), 32'd1);

        // Overflow on full, then clear.
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd16);
        chk("ovf_rdata", 32'(bus.rdata), 32'h00);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(bus.overflow), 32'd0);

        // Push+pop when full: both execute.
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("pp_full_count", 32'(bus.count), 32'd16);
        chk("pp_full_full", 32'(bus.full), 32'd1);
        chk("pp_full_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            exp_d = (i < 15) ? DW'(i + 1) : 8'h55;
            chk("drain_rdata", 32'(bus.rdata), 32'(exp_d));
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);

        // Underflow cases.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("unf_set", 32'(bus.underflow), 32'd1);
        chk("unf_empty", 32'(bus.empty), 32'd1);
        chk("unf_count", 32'(bus.count), 32'd0);
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("pp_empty_count", 32'(bus.count), 32'd1);
        chk("pp_empty_rdata", 32'(bus.rdata), 32'h3C);
        chk("pp_empty_unf", 32'(bus.underflow), 32'd1);
        // Clear coinciding with a new underflow: set wins.
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("clr_vs_set", 32'(bus.underflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("unf_clr", 32'(bus.underflow), 32'd0);

        // Flush with push.
        for (int i = 0; i < 5; i++)
            step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        chk("flush_ae", 32'(bus.almost_empty), 32'd1);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("post_flush_rdata", 32'(bus.rdata), 32'h77);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Wrap-around with occupancy 3.
        for (int i = 0; i < 3; i++)
            step(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            exp_d = (k < 3) ? DW'(8'hA0 + k) : DW'(8'h80 + k - 3);
            chk("wrap_rdata", 32'(bus.rdata), 32'(exp_d));
            step(1'b1, DW'(8'h80 + k), 1'b1, 1'b0, 1'b0);
            chk("wrap_count", 32'(bus.count), 32'd3);
            chk("wrap_ae", 32'(bus.almost_empty), 32'd0);
        end

        // Random traffic, fill-biased then drain-biased.
        for (int i = 0; i < 3000; i++) begin
            int pp;
            pp = (i % 1000 < 500) ? 70 : 35;
            step(($urandom_range(0, 99) < pp), DW'($urandom),
                 ($urandom_range(0, 99) < 100 - pp),
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 5));
        end

        // Mid-cycle asynchronous reset with overflow set.
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++)
            step(1'b1, DW'($urandom), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_ovf", 32'(bus.overflow), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++)
            step(($urandom_range(0, 1) == 1), DW'($urandom),
                 ($urandom_range(0, 1) == 1), 1'b0,
                 ($urandom_range(0, 9) == 0));

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule
